// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle for the two requesters (A = ALU, B = load) that
// share the register file write port.
interface regfile_wr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file write port, with read pass-through.
// Define REGFILE_WR_ARBITER_BYPASS_EN to forward the in-flight write to the read ports.
module regfile_wr_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  wr,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [DW-1:0]        rf_rdata1,
    input  logic [DW-1:0]        rf_rdata2,
    output logic [DW-1:0]        rd_data1,
    output logic [DW-1:0]        rd_data2,
    output logic [CW-1:0]        conflict_cnt
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          rf_we_reg;
    logic [AW-1:0] rf_waddr_reg;
    logic [DW-1:0] rf_wdata_reg;
    logic [CW-1:0] cnt_reg;
    logic          last_b_reg;   // 1: B won the last transfer, so A wins the next tie

    logic grant_a;
    logic grant_b;
    logic xfer_a;
    logic xfer_b;
    logic conflict;

    assign conflict = wr.a_valid && wr.b_valid;
    assign grant_a  = wr.a_valid && (!wr.b_valid || last_b_reg);
    assign grant_b  = wr.b_valid && (!wr.a_valid || !last_b_reg);

    assign wr.a_ready = grant_a && !rst;
    assign wr.b_ready = grant_b && !rst;

    assign xfer_a = wr.a_valid && wr.a_ready;
    assign xfer_b = wr.b_valid && wr.b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            cnt_reg      <= '0;
            last_b_reg   <= 1'b1;
        end else begin
            // Register 0 is hardwired: the handshake completes but no write is issued.
            if (xfer_a) begin
                rf_we_reg    <= (wr.a_addr != '0);
                rf_waddr_reg <= wr.a_addr;
                rf_wdata_reg <= wr.a_data;
                last_b_reg   <= 1'b0;
            end else if (xfer_b) begin
                rf_we_reg    <= (wr.b_addr != '0);
                rf_waddr_reg <= wr.b_addr;
                rf_wdata_reg <= wr.b_data;
                last_b_reg   <= 1'b1;
            end else begin
                rf_we_reg    <= 1'b0;
            end

            if (conflict && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign rf_we        = rf_we_reg;
    assign rf_waddr     = rf_waddr_reg;
    assign rf_wdata     = rf_wdata_reg;
    assign conflict_cnt = cnt_reg;

    assign rf_raddr1 = rd_addr1;
    assign rf_raddr2 = rd_addr2;

    logic [AW-1:0] rd_addr_arr  [2];
    logic [DW-1:0] rf_rdata_arr [2];
    logic [DW-1:0] rd_data_arr  [2];

    assign rd_addr_arr[0]  = rd_addr1;
    assign rd_addr_arr[1]  = rd_addr2;
    assign rf_rdata_arr[0] = rf_rdata1;
    assign rf_rdata_arr[1] = rf_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_WR_ARBITER_BYPASS_EN
            assign rd_data_arr[gi] = (rf_we_reg && (rf_waddr_reg != '0) &&
                                      (rd_addr_arr[gi] == rf_waddr_reg))
                                     ? rf_wdata_reg : rf_rdata_arr[gi];
`else
            logic [AW-1:0] addr_unused;
            assign addr_unused     = rd_addr_arr[gi];
            assign rd_data_arr[gi] = rf_rdata_arr[gi];
`endif
        end
    endgenerate

    assign rd_data1 = rd_data_arr[0];
    assign rd_data2 = rd_data_arr[1];
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter, plus a CW=4 instance
// for counter saturation.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter_if #(.AW(5), .DW(32)) wr_if ();
    regfile_wr_arbiter_if #(.AW(5), .DW(32)) sat_if ();

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr1, rd_addr2, rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2, rd_data1, rd_data2;
    logic [15:0] conflict_cnt;

    logic        s_we;
    logic [4:0]  s_waddr, s_raddr1, s_raddr2;
    logic [31:0] s_wdata, s_rd1, s_rd2;
    logic [3:0]  s_cnt;

    regfile_wr_arbiter #(.AW(5), .DW(32), .CW(16)) dut (
        .clk(clk), .rst(rst), .wr(wr_if.slave),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wr_arbiter #(.AW(5), .DW(32), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .wr(sat_if.slave),
        .rf_we(s_we), .rf_waddr(s_waddr), .rf_wdata(s_wdata),
        .rd_addr1(5'd0), .rd_addr2(5'd0),
        .rf_raddr1(s_raddr1), .rf_raddr2(s_raddr2),
        .rf_rdata1(32'd0), .rf_rdata2(32'd0),
        .rd_data1(s_rd1), .rd_data2(s_rd2),
        .conflict_cnt(s_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wr_if.a_valid = 0; wr_if.a_addr = 0; wr_if.a_data = 0;
        wr_if.b_valid = 0; wr_if.b_addr = 0; wr_if.b_data = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        wr_if.a_valid = 1; wr_if.a_addr = 5'h15; wr_if.a_data = 32'habcdef12;
        #1;
        checks++;
        if (wr_if.a_ready !== 1'b0 || wr_if.b_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: a_ready=%b b_ready=%b expected 0 0", wr_if.a_ready, wr_if.b_ready);
        end
        step; step;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'h0 || rf_wdata !== 32'h0 || conflict_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_state: we=%b waddr=%h wdata=%h cnt=%0d expected 0 0 0 0", rf_we, rf_waddr, rf_wdata, conflict_cnt);
        end
        rst = 0;
        #1;
        checks++;
        if (wr_if.a_ready !== 1'b1 || wr_if.b_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: a_ready=%b b_ready=%b expected 1 0", wr_if.a_ready, wr_if.b_ready);
        end
        step;
        wr_if.a_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'h15 || rf_wdata !== 32'habcdef12) begin
            errors++; $display("FAIL single_write: we=%b waddr=%h wdata=%h expected 1 15 abcdef12", rf_we, rf_waddr, rf_wdata);
        end
        step;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'h15 || rf_wdata !== 32'habcdef12) begin
            errors++; $display("FAIL single_idle: we=%b waddr=%h wdata=%h expected 0 15 abcdef12", rf_we, rf_waddr, rf_wdata);
        end
        $display("single write: we=%b waddr=%h wdata=%h", rf_we, rf_waddr, rf_wdata);
    endtask

    task automatic test_round_robin;
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        rst = 1; idle_inputs(); step; rst = 0;
        wr_if.a_valid = 1; wr_if.a_addr = 5'h0A; wr_if.a_data = 32'h12345678;
        wr_if.b_valid = 1; wr_if.b_addr = 5'h03; wr_if.b_data = 32'h0000beef;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (wr_if.a_ready !== (i % 2 == 0) || wr_if.b_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b expected %b %b", i, wr_if.a_ready, wr_if.b_ready, (i % 2 == 0), (i % 2 == 1));
            end
            step;
            exp_addr = (i % 2 == 0) ? 5'h0A : 5'h03;
            exp_data = (i % 2 == 0) ? 32'h12345678 : 32'h0000beef;
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin
                errors++; $display("FAIL rr_write[%0d]: we=%b waddr=%h wdata=%h expected 1 %h %h", i, rf_we, rf_waddr, rf_wdata, exp_addr, exp_data);
            end
            $display("rr cycle %0d: waddr=%h wdata=%h", i, rf_waddr, rf_wdata);
        end
        idle_inputs();
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++; $display("FAIL rr_conflicts: cnt=%0d expected 4", conflict_cnt);
        end
    endtask

    task automatic test_reg0;
        wr_if.b_valid = 1; wr_if.b_addr = 5'h00; wr_if.b_data = 32'hffffffff;
        #1;
        checks++;
        if (wr_if.b_ready !== 1'b1 || wr_if.a_ready !== 1'b0) begin
            errors++; $display("FAIL reg0_ready: a_ready=%b b_ready=%b expected 0 1", wr_if.a_ready, wr_if.b_ready);
        end
        step;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'h00 || rf_wdata !== 32'hffffffff) begin
            errors++; $display("FAIL reg0_drop: we=%b waddr=%h wdata=%h expected 0 00 ffffffff", rf_we, rf_waddr, rf_wdata);
        end
        // Tie after the reg-0 write: A must win because B was last granted.
        wr_if.a_valid = 1; wr_if.a_addr = 5'h01; wr_if.a_data = 32'h00c0ffee;
        wr_if.b_addr = 5'h02; wr_if.b_data = 32'h11111111;
        #1;
        checks++;
        if (wr_if.a_ready !== 1'b1 || wr_if.b_ready !== 1'b0) begin
            errors++; $display("FAIL reg0_next_grant: a_ready=%b b_ready=%b expected 1 0", wr_if.a_ready, wr_if.b_ready);
        end
        step;
        idle_inputs();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'h01 || rf_wdata !== 32'h00c0ffee || conflict_cnt !== 16'd5) begin
            errors++; $display("FAIL reg0_next_write: we=%b waddr=%h wdata=%h cnt=%0d expected 1 01 00c0ffee 5", rf_we, rf_waddr, rf_wdata, conflict_cnt);
        end
        $display("reg0 then A: waddr=%h cnt=%0d", rf_waddr, conflict_cnt);
    endtask

    task automatic test_reset_mid;
        wr_if.a_valid = 1; wr_if.a_addr = 5'h07; wr_if.a_data = 32'h77777777;
        step;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'h07) begin
            errors++; $display("FAIL mid_accept: we=%b waddr=%h expected 1 07", rf_we, rf_waddr);
        end
        rst = 1;
        wr_if.b_valid = 1; wr_if.b_addr = 5'h08;
        #1;
        checks++;
        if (wr_if.a_ready !== 1'b0 || wr_if.b_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready: a_ready=%b b_ready=%b expected 0 0", wr_if.a_ready, wr_if.b_ready);
        end
        step;
        checks++;
        if (rf_we !== 1'b0 || conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset: we=%b cnt=%0d expected 0 0", rf_we, conflict_cnt);
        end
        rst = 0;
        idle_inputs();
        $display("reset mid-stream: we=%b cnt=%0d", rf_we, conflict_cnt);
    endtask

    task automatic test_bypass;
        logic [31:0] exp1;
`ifdef REGFILE_WR_ARBITER_BYPASS_EN
        exp1 = 32'h12345678;
`else
        exp1 = 32'h00000000;
`endif
        rd_addr1 = 5'h0A; rf_rdata1 = 32'h0;
        rd_addr2 = 5'h0B; rf_rdata2 = 32'h55555555;
        wr_if.a_valid = 1; wr_if.a_addr = 5'h0A; wr_if.a_data = 32'h12345678;
        step;
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b1 || rd_data1 !== exp1) begin
            errors++; $display("FAIL bypass_hit: we=%b rd_data1=%h expected 1 %h", rf_we, rd_data1, exp1);
        end
        checks++;
        if (rd_data2 !== 32'h55555555 || rf_raddr1 !== 5'h0A || rf_raddr2 !== 5'h0B) begin
            errors++; $display("FAIL bypass_other: rd_data2=%h raddr1=%h raddr2=%h expected 55555555 0a 0b", rd_data2, rf_raddr1, rf_raddr2);
        end
        step;
        checks++;
        if (rd_data1 !== 32'h0) begin
            errors++; $display("FAIL bypass_after: rd_data1=%h expected 00000000", rd_data1);
        end
        $display("read path: rd_data1=%h rd_data2=%h", rd_data1, rd_data2);
    endtask

    task automatic test_saturation;
        sat_if.a_valid = 1; sat_if.a_addr = 5'h04; sat_if.a_data = 32'h1;
        sat_if.b_valid = 1; sat_if.b_addr = 5'h05; sat_if.b_data = 32'h2;
        for (int i = 0; i < 10; i++) step;
        checks++;
        if (s_cnt !== 4'd10) begin
            errors++; $display("FAIL sat_mid: cnt=%0d expected 10", s_cnt);
        end
        for (int i = 0; i < 10; i++) step;
        checks++;
        if (s_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_hold: cnt=%0d expected 15", s_cnt);
        end
        sat_if.a_valid = 0; sat_if.b_valid = 0;
        $display("saturation: cnt=%0d", s_cnt);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        sat_if.a_valid = 0; sat_if.a_addr = 0; sat_if.a_data = 0;
        sat_if.b_valid = 0; sat_if.b_addr = 0; sat_if.b_data = 0;
        rd_addr1 = 0; rd_addr2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        test_reset();
        test_round_robin();
        test_reg0();
        test_reset_mid();
        test_bypass();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU result) and B (memory load).
- Arbitration is round-robin. The granted write is registered and driven to the register file one cycle later.
- Read ports pass through the block to the register file.
- The block keeps a saturating count of arbitration conflicts for debug.

Parameters:
- AW, 5, register address width (32 registers).
- DW, 32, data width.
- CW, 16, conflict counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write accepted this cycle.
- a_addr  in  AW  A destination register.
- a_data  in  DW  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write accepted this cycle.
- b_addr  in  AW  B destination register.
- b_data  in  DW  B write data.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  DW  register file write data (registered).
- rd_addr1  in  AW  read port 1 address; driven straight to rf_raddr1.
- rd_addr2  in  AW  read port 2 address; driven straight to rf_raddr2.
- rf_raddr1  out  AW  to register file raddr1.
- rf_raddr2  out  AW  to register file raddr2.
- rf_rdata1  in  DW  from register file rdata1.
- rf_rdata2  in  DW  from register file rdata2.
- rd_data1  out  DW  read result port 1.
- rd_data2  out  DW  read result port 2.
- conflict_cnt  out  CW  cycles where both requesters were valid; saturating.

Behaviour:
- Reset:
  - rst is synchronous and active-high; clk is the single clock.
  - While rst=1, on the clock edge: rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, last_grant=B (so A wins the first tie).
  - While rst=1, a_ready=0 and b_ready=0 combinationally; no handshake completes.
- Grant (combinational from the valids and last_grant):
  - only a_valid: grant A.
  - only b_valid: grant B.
  - both valid: grant the requester that is not last_grant.
  - neither valid: no grant.
- Ready:
  - a_ready = grant A and !rst; b_ready = grant B and !rst.
  - At most one ready is high per cycle.
  - Ready does not depend on the requester's own valid beyond the grant logic.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at the edge.
  - A requester holds addr and data stable while its valid is 1 and its ready is 0.
  - The losing requester stays pending with no data loss.
- Pipeline:
  - On a transfer, the next edge loads rf_waddr and rf_wdata from the winner and sets rf_we=1. Latency from accept to write is 1 cycle.
  - With no transfer, rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - Throughput is one write per cycle.
  - last_grant updates only on a transfer.
- Register 0:
  - A transfer with addr=0 completes the handshake.
  - rf_we stays 0 for that cycle; waddr and wdata still load.
  - last_grant still updates.
- conflict_cnt:
  - Increments on every edge where a_valid and b_valid are both 1 and rst=0.
  - Saturates at 2^CW-1; no wrap.
- Reset mid-operation:
  - A write already in the output register when rst rises is dropped (rf_we cleared).
  - Requesters must re-present after reset.
- Read path without the bypass feature: rd_dataN = rf_rdataN.

Optional Feature:
- Macro: REGFILE_WR_ARBITER_BYPASS_EN.
- Defined:
  - If rf_we=1, rf_waddr!=0 and rd_addrN==rf_waddr, then rd_dataN=rf_wdata. Otherwise rd_dataN=rf_rdataN.
  - Both ports are checked independently.
  - Gives same-cycle read-after-write forwarding.
- Undefined:
  - Pure pass-through.
  - A read of a register being written this cycle returns the old value.

Test Plan:
- Reset then a single write: rst=1 for 2 cycles, then a_valid=1, a_addr=5'h15, a_data=32'habcdef12 → a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5'h15, rf_wdata=32'habcdef12; following cycle rf_we=0.
- Tie round-robin: a_valid and b_valid held at 1 for 4 cycles (A addr 5'h0A data 32'h12345678, B addr 5'h03 data 32'h0000beef) → grants A,B,A,B; rf_waddr sequence 0A,03,0A,03 one cycle delayed; conflict_cnt=4.
- Register 0 drop: b_valid=1, b_addr=0, b_data=32'hffffffff → b_ready=1; next cycle rf_we=0. A following A write to 5'h01 is granted normally (last_grant=B).
- Reset mid-stream: transfer accepted, rst=1 on the next edge → rf_we=0, conflict_cnt=0, both readies 0 while rst=1.
- Bypass (macro defined): write 32'h12345678 to 5'h0A accepted; in the rf_we cycle rd_addr1=5'h0A, rf_rdata1=32'h0 → rd_data1=32'h12345678. Same stimulus with the macro undefined → rd_data1=32'h0.
- Saturation (CW=4 build): both valid for 20 cycles → conflict_cnt stops at 4'hF.
